// File: rtl/dvfs_pkg.sv
// Shared types, default limits and the code-clamp helper for the DVFS
// transition sequencer.
package dvfs_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_VSET  = 3'd1,
        ST_VWAIT = 3'd2,
        ST_FSET  = 3'd3,
        ST_FWAIT = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    typedef struct packed {
        logic [2:0] voltage;
        logic [2:0] freq;
    } op_point_t;

    localparam int unsigned DefMinVoltage    = 32'd0;
    localparam int unsigned DefMaxVoltage    = 32'd5;
    localparam int unsigned DefMinFreq       = 32'd1;
    localparam int unsigned DefMaxFreq       = 32'd7;
    localparam int unsigned DefSettleCycles  = 32'd4;
    localparam int unsigned DefTimeoutCycles = 32'd64;

    function automatic logic [2:0] clamp_code(input logic [2:0] code,
                                              input logic [2:0] lo,
                                              input logic [2:0] hi);
        logic [2:0] res;
        if (code < lo) begin
            res = lo;
        end else if (code > hi) begin
            res = hi;
        end else begin
            res = code;
        end
        return res;
    endfunction

endpackage

// File: rtl/dvfs_step_waiter.sv
// One actuator step: waits for ack/lock under a timeout, then lets the
// output settle for SettleCycles before confirming.
module dvfs_step_waiter
    import dvfs_pkg::*;
#(
    parameter int unsigned SettleCycles  = DefSettleCycles,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic ack_i,
    output logic confirm_o,
    output logic timeout_o
);

    localparam logic [15:0] SettleLast  = (SettleCycles > 32'd0) ? 16'(SettleCycles - 32'd1) : 16'd0;
    localparam logic [15:0] TimeoutLast = 16'(TimeoutCycles - 32'd1);

    logic        waiting_r;
    logic        settling_r;
    logic [15:0] timer_r;
    logic [15:0] settle_r;
    logic        confirm_s;
    logic        timeout_s;

    // Confirm/timeout decode; an ack in the final timeout cycle still wins.
    always_comb begin
        confirm_s = 1'b0;
        timeout_s = 1'b0;
        if (waiting_r) begin
            if (SettleCycles == 32'd0) begin
                confirm_s = ack_i;
            end else begin
                confirm_s = 1'b0;
            end
            timeout_s = !ack_i && (timer_r == TimeoutLast);
        end else if (settling_r) begin
            confirm_s = (settle_r == SettleLast);
        end else begin
            confirm_s = 1'b0;
            timeout_s = 1'b0;
        end
    end

    // Wait/settle tracking with saturating 16-bit counters.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            waiting_r  <= 1'b0;
            settling_r <= 1'b0;
            timer_r    <= 16'd0;
            settle_r   <= 16'd0;
        end else if (start_i) begin
            waiting_r  <= 1'b1;
            settling_r <= 1'b0;
            timer_r    <= 16'd0;
            settle_r   <= 16'd0;
        end else if (waiting_r) begin
            if (ack_i) begin
                waiting_r  <= 1'b0;
                settling_r <= (SettleCycles != 32'd0);
                settle_r   <= 16'd0;
            end else if (timeout_s) begin
                waiting_r <= 1'b0;
            end else if (timer_r != 16'hFFFF) begin
                timer_r <= timer_r + 16'd1;
            end
        end else if (settling_r) begin
            if (confirm_s) begin
                settling_r <= 1'b0;
            end else if (settle_r != 16'hFFFF) begin
                settle_r <= settle_r + 16'd1;
            end
        end
    end

    assign confirm_o = confirm_s;
    assign timeout_o = timeout_s;

endmodule

// File: rtl/dvfs_transition_sequencer.sv
// Applies one (voltage, frequency) operating point at a time: voltage before
// frequency when raising, frequency before voltage when lowering.
module dvfs_transition_sequencer
    import dvfs_pkg::*;
#(
    parameter int unsigned MinVoltage    = DefMinVoltage,
    parameter int unsigned MaxVoltage    = DefMaxVoltage,
    parameter int unsigned MinFreq       = DefMinFreq,
    parameter int unsigned MaxFreq       = DefMaxFreq,
    parameter int unsigned SettleCycles  = DefSettleCycles,
    parameter int unsigned TimeoutCycles = DefTimeoutCycles
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [2:0] def_voltage_i,
    input  logic [2:0] def_freq_i,
    input  logic       req_valid_i,
    output logic       req_ready_o,
    input  logic [2:0] req_voltage_i,
    input  logic [2:0] req_freq_i,
    output logic       vreg_req_o,
    output logic [2:0] vreg_voltage_o,
    input  logic       vreg_ack_i,
    output logic       clk_req_o,
    output logic [2:0] clk_freq_o,
    input  logic       clk_lock_i,
    output logic [2:0] cur_voltage_o,
    output logic [2:0] cur_freq_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o
);

    state_e     state_r;
    op_point_t  tgt_r;
    logic       v_first_r;
    logic [2:0] req_v_s;
    logic [2:0] req_f_s;
    logic       v_confirm_s;
    logic       v_timeout_s;
    logic       f_confirm_s;
    logic       f_timeout_s;

    // Requests are clamped before they are compared or latched.
    always_comb begin
        req_v_s = clamp_code(req_voltage_i, 3'(MinVoltage), 3'(MaxVoltage));
        req_f_s = clamp_code(req_freq_i, 3'(MinFreq), 3'(MaxFreq));
    end

    dvfs_step_waiter #(
        .SettleCycles  (SettleCycles),
        .TimeoutCycles (TimeoutCycles)
    ) u_v_waiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (state_r == ST_VSET),
        .ack_i     (vreg_ack_i),
        .confirm_o (v_confirm_s),
        .timeout_o (v_timeout_s)
    );

    dvfs_step_waiter #(
        .SettleCycles  (SettleCycles),
        .TimeoutCycles (TimeoutCycles)
    ) u_f_waiter (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .start_i   (state_r == ST_FSET),
        .ack_i     (clk_lock_i),
        .confirm_o (f_confirm_s),
        .timeout_o (f_timeout_s)
    );

    assign req_ready_o = (state_r == ST_IDLE);
    assign busy_o      = (state_r != ST_IDLE);

    // Sequencer FSM; strobes and pulses are registered on entry to their state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r        <= ST_IDLE;
            tgt_r          <= '0;
            v_first_r      <= 1'b0;
            vreg_req_o     <= 1'b0;
            vreg_voltage_o <= def_voltage_i;
            clk_req_o      <= 1'b0;
            clk_freq_o     <= def_freq_i;
            cur_voltage_o  <= def_voltage_i;
            cur_freq_o     <= def_freq_i;
            done_o         <= 1'b0;
            err_o          <= 1'b0;
        end else begin
            vreg_req_o <= 1'b0;
            clk_req_o  <= 1'b0;
            done_o     <= 1'b0;
            err_o      <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        tgt_r.voltage <= req_v_s;
                        tgt_r.freq    <= req_f_s;
                        v_first_r     <= (req_v_s > cur_voltage_o);
                        if ((req_v_s == cur_voltage_o) && (req_f_s == cur_freq_o)) begin
                            state_r <= ST_DONE;
                            done_o  <= 1'b1;
                        end else if ((req_v_s > cur_voltage_o) || (req_f_s == cur_freq_o)) begin
                            state_r        <= ST_VSET;
                            vreg_voltage_o <= req_v_s;
                            vreg_req_o     <= 1'b1;
                        end else begin
                            state_r    <= ST_FSET;
                            clk_freq_o <= req_f_s;
                            clk_req_o  <= 1'b1;
                        end
                    end
                end
                ST_VSET: state_r <= ST_VWAIT;
                ST_VWAIT: begin
                    if (v_confirm_s) begin
                        cur_voltage_o <= tgt_r.voltage;
                        if (v_first_r && (tgt_r.freq != cur_freq_o)) begin
                            state_r    <= ST_FSET;
                            clk_freq_o <= tgt_r.freq;
                            clk_req_o  <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_o  <= 1'b1;
                        end
                    end else if (v_timeout_s) begin
                        state_r        <= ST_ERR;
                        err_o          <= 1'b1;
                        vreg_voltage_o <= cur_voltage_o;
                        clk_freq_o     <= cur_freq_o;
                        vreg_req_o     <= 1'b1;
                    end
                end
                ST_FSET: state_r <= ST_FWAIT;
                ST_FWAIT: begin
                    if (f_confirm_s) begin
                        cur_freq_o <= tgt_r.freq;
                        if (!v_first_r && (tgt_r.voltage != cur_voltage_o)) begin
                            state_r        <= ST_VSET;
                            vreg_voltage_o <= tgt_r.voltage;
                            vreg_req_o     <= 1'b1;
                        end else begin
                            state_r <= ST_DONE;
                            done_o  <= 1'b1;
                        end
                    end else if (f_timeout_s) begin
                        state_r        <= ST_ERR;
                        err_o          <= 1'b1;
                        vreg_voltage_o <= cur_voltage_o;
                        clk_freq_o     <= cur_freq_o;
                        clk_req_o      <= 1'b1;
                    end
                end
                ST_DONE: state_r <= ST_IDLE;
                ST_ERR:  state_r <= ST_IDLE;
                default: state_r <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dvfs_transition_sequencer.sv
// Randomized self-checking bench: an actuator model answers strobes and a
// step-list reference model predicts strobes, pulse timing and final point.
module tb_dvfs_transition_sequencer;

    localparam int S = 4;
    localparam int T = 64;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic [2:0] def_voltage_i = 3'd2;
    logic [2:0] def_freq_i = 3'd3;
    logic       req_valid_i = 1'b0;
    logic       req_ready_o;
    logic [2:0] req_voltage_i = 3'd0;
    logic [2:0] req_freq_i = 3'd0;
    logic       vreg_req_o;
    logic [2:0] vreg_voltage_o;
    logic       vreg_ack_i = 1'b0;
    logic       clk_req_o;
    logic [2:0] clk_freq_o;
    logic       clk_lock_i = 1'b0;
    logic [2:0] cur_voltage_o;
    logic [2:0] cur_freq_o;
    logic       busy_o;
    logic       done_o;
    logic       err_o;

    int checks = 0;
    int errors = 0;
    int m_v = 2;
    int m_f = 3;

    dvfs_transition_sequencer #(
        .SettleCycles  (S),
        .TimeoutCycles (T)
    ) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .def_voltage_i  (def_voltage_i),
        .def_freq_i     (def_freq_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_voltage_i  (req_voltage_i),
        .req_freq_i     (req_freq_i),
        .vreg_req_o     (vreg_req_o),
        .vreg_voltage_o (vreg_voltage_o),
        .vreg_ack_i     (vreg_ack_i),
        .clk_req_o      (clk_req_o),
        .clk_freq_o     (clk_freq_o),
        .clk_lock_i     (clk_lock_i),
        .cur_voltage_o  (cur_voltage_o),
        .cur_freq_o     (cur_freq_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    // Event code: kind*100000 + cycle*10 + value (kind 0 = regulator, 1 = clock).
    task automatic run_txn(input int v, input int f, input int kv, input int kf,
                           input bit drop_v, input bit drop_f, input bit extra);
        int tv, tf, nv, nf, t, kind, kk, exp_done, exp_err, obs_done, obs_err;
        int v_ack_at, f_ack_at;
        bit vfirst, act, drop, busy_bad, stop;
        int expq[$];
        int obsq[$];
        tv = (v > 5) ? 5 : v;
        tf = (f < 1) ? 1 : ((f > 7) ? 7 : f);
        vfirst = (tv > m_v);
        nv = m_v; nf = m_f; t = 0; exp_done = -1; exp_err = -1;
        for (int s = 0; s < 2; s++) begin
            kind = ((s == 0) == vfirst) ? 0 : 1;
            act  = (kind == 0) ? (tv != nv) : (tf != nf);
            if (act && exp_err < 0) begin
                t += 1;
                expq.push_back(kind * 100000 + t * 10 + ((kind == 0) ? tv : tf));
                drop = (kind == 0) ? drop_v : drop_f;
                kk   = (kind == 0) ? kv : kf;
                if (drop) begin
                    exp_err = t + T + 1;
                    expq.push_back(kind * 100000 + exp_err * 10 + ((kind == 0) ? nv : nf));
                end else begin
                    t += kk + S;
                    if (kind == 0) nv = tv; else nf = tf;
                end
            end
        end
        if (exp_err < 0) exp_done = t + 1;

        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL ready_before: got %b expected 1", req_ready_o);
        end
        req_voltage_i = 3'(v); req_freq_i = 3'(f); req_valid_i = 1'b1;
        stop = 1'b0; obs_done = -1; obs_err = -1; busy_bad = 1'b0; v_ack_at = -1; f_ack_at = -1;
        for (int c = 1; c <= 400 && !stop; c++) begin
            @(negedge clk_i);
            if (c == 1) req_valid_i = 1'b0;
            if (extra && c == 3) begin
                req_valid_i = 1'b1;
                req_voltage_i = 3'($urandom_range(0, 7));
                req_freq_i = 3'($urandom_range(0, 7));
            end
            if (c == 4) req_valid_i = 1'b0;
            if (busy_o !== 1'b1 || req_ready_o !== 1'b0) busy_bad = 1'b1;
            if (vreg_req_o === 1'b1) begin
                obsq.push_back(c * 10 + int'(vreg_voltage_o));
                if (err_o !== 1'b1 && !drop_v) v_ack_at = c + kv;
            end
            if (clk_req_o === 1'b1) begin
                obsq.push_back(100000 + c * 10 + int'(clk_freq_o));
                if (err_o !== 1'b1 && !drop_f) f_ack_at = c + kf;
            end
            if (done_o === 1'b1) begin obs_done = c; stop = 1'b1; end
            if (err_o === 1'b1) begin obs_err = c; stop = 1'b1; end
            vreg_ack_i = (c == v_ack_at);
            clk_lock_i = (c == f_ack_at);
        end
        vreg_ack_i = 1'b0;
        clk_lock_i = 1'b0;

        checks++;
        if (obsq.size() != expq.size()) begin
            errors++;
            $display("FAIL strobe_count: got %0d expected %0d (req %0d/%0d)", obsq.size(), expq.size(), v, f);
        end
        for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
            checks++;
            if (obsq[i] != expq[i]) begin
                errors++;
                $display("FAIL strobe_event[%0d]: got %0d expected %0d", i, obsq[i], expq[i]);
            end
        end
        checks++;
        if (obs_done != exp_done) begin
            errors++;
            $display("FAIL done_cycle: got %0d expected %0d", obs_done, exp_done);
        end
        checks++;
        if (obs_err != exp_err) begin
            errors++;
            $display("FAIL err_cycle: got %0d expected %0d", obs_err, exp_err);
        end
        checks++;
        if (busy_bad) begin
            errors++;
            $display("FAIL busy_during: got not-busy expected busy and not ready");
        end
        checks++;
        if (int'(cur_voltage_o) != nv || int'(cur_freq_o) != nf) begin
            errors++;
            $display("FAIL cur_point: got %0d/%0d expected %0d/%0d", cur_voltage_o, cur_freq_o, nv, nf);
        end
        checks++;
        if (int'(vreg_voltage_o) != nv || int'(clk_freq_o) != nf) begin
            errors++;
            $display("FAIL cmd_point: got %0d/%0d expected %0d/%0d", vreg_voltage_o, clk_freq_o, nv, nf);
        end
        @(negedge clk_i);
        checks++;
        if (req_ready_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL back_to_idle: got rdy=%b busy=%b done=%b err=%b expected 1 0 0 0",
                     req_ready_o, busy_o, done_o, err_o);
        end
        m_v = nv;
        m_f = nf;
    endtask

    task automatic test_reset();
        checks++;
        if (cur_voltage_o !== 3'd2 || cur_freq_o !== 3'd3 || vreg_voltage_o !== 3'd2 || clk_freq_o !== 3'd3) begin
            errors++;
            $display("FAIL reset_point: got cur %0d/%0d cmd %0d/%0d expected 2/3 2/3",
                     cur_voltage_o, cur_freq_o, vreg_voltage_o, clk_freq_o);
        end
        checks++;
        if (vreg_req_o !== 1'b0 || clk_req_o !== 1'b0 || busy_o !== 1'b0 || done_o !== 1'b0 ||
            err_o !== 1'b0 || req_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_flags: got vreq=%b creq=%b busy=%b done=%b err=%b rdy=%b expected 0 0 0 0 0 1",
                     vreg_req_o, clk_req_o, busy_o, done_o, err_o, req_ready_o);
        end
    endtask

    task automatic test_raise();
        run_txn(4, 5, 1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_lower();
        run_txn(1, 2, 1, 1, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_noop_clamp();
        run_txn(1, 2, 1, 1, 1'b0, 1'b0, 1'b0);
        run_txn(7, 0, 2, 3, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        run_txn(2, 3, 1, 2, 1'b0, 1'b0, 1'b0);
        run_txn(4, 5, 1, 1, 1'b1, 1'b0, 1'b0);
        run_txn(4, 5, 3, 1, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_busy_request();
        run_txn(1, 7, 2, 1, 1'b0, 1'b0, 1'b1);
        run_txn(5, 2, 1, 4, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_txn($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(1, 5), $urandom_range(1, 5),
                    ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0), $urandom_range(0, 1) == 1);
        end
    endtask

    task automatic test_reset_mid();
        run_txn(2, 3, 1, 1, 1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        req_voltage_i = 3'd4; req_freq_i = 3'd5; req_valid_i = 1'b1;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk_i);
            if (c == 1) begin
                req_valid_i = 1'b0;
                checks++;
                if (vreg_req_o !== 1'b1) begin
                    errors++;
                    $display("FAIL mid_vstrobe: got %b expected 1", vreg_req_o);
                end
            end
            if (c == 7) begin
                checks++;
                if (clk_req_o !== 1'b1 || clk_freq_o !== 3'd5 || cur_voltage_o !== 3'd4) begin
                    errors++;
                    $display("FAIL mid_fstrobe: got creq=%b freq=%0d curv=%0d expected 1 5 4",
                             clk_req_o, clk_freq_o, cur_voltage_o);
                end
            end
            vreg_ack_i = (c == 2);
        end
        vreg_ack_i = 1'b0;
        def_voltage_i = 3'd1;
        def_freq_i = 3'd6;
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (cur_voltage_o !== 3'd1 || cur_freq_o !== 3'd6 || vreg_voltage_o !== 3'd1 || clk_freq_o !== 3'd6 ||
            busy_o !== 1'b0 || done_o !== 1'b0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: got cur %0d/%0d cmd %0d/%0d busy=%b done=%b err=%b expected 1/6 1/6 0 0 0",
                     cur_voltage_o, cur_freq_o, vreg_voltage_o, clk_freq_o, busy_o, done_o, err_o);
        end
        repeat (2) @(negedge clk_i);
        rst_ni = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk_i);
            checks++;
            if (done_o !== 1'b0 || err_o !== 1'b0 || req_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL post_reset_quiet: got done=%b err=%b rdy=%b expected 0 0 1", done_o, err_o, req_ready_o);
            end
        end
        m_v = 1;
        m_f = 6;
        run_txn(3, 4, 2, 2, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        @(negedge clk_i);
        test_reset();
        test_raise();
        test_lower();
        test_noop_clamp();
        test_timeout();
        test_busy_request();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
